// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, round count, round-constant table and
// the FSM state encoding used by the key schedule.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam int NUM_ROUNDS = 10;

  // Indexed by round number 1..10; the unused slots keep every 4-bit index defined.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] rcon_lookup(input logic [3:0] i_idx);
    return RCON[i_idx];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Computed rather than tabulated so the substitution is correct by construction.
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] i_a, input logic [7:0] i_b);
    logic [7:0] v_p;
    logic [7:0] v_a;
    v_p = 8'h00;
    v_a = i_a;
    for (int i = 0; i < 8; i++) begin
      if (i_b[i]) v_p = v_p ^ v_a;
      v_a = v_a[7] ? ({v_a[6:0], 1'b0} ^ 8'h1b) : {v_a[6:0], 1'b0};
    end
    return v_p;
  endfunction

  logic [7:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_x64, w_x128;
  logic [7:0] w_inv;

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  assign w_x2   = gf_mul(i_in, i_in);
  assign w_x4   = gf_mul(w_x2, w_x2);
  assign w_x8   = gf_mul(w_x4, w_x4);
  assign w_x16  = gf_mul(w_x8, w_x8);
  assign w_x32  = gf_mul(w_x16, w_x16);
  assign w_x64  = gf_mul(w_x32, w_x32);
  assign w_x128 = gf_mul(w_x64, w_x64);
  assign w_inv  = gf_mul(gf_mul(gf_mul(w_x2, w_x4), gf_mul(w_x8, w_x16)),
                         gf_mul(gf_mul(w_x32, w_x64), w_x128));

  assign o_out = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: accepts a cipher key, then streams round keys 0..10
// over a valid/ready interface, one round per accepted handshake.
//
// state | meaning
// IDLE  | waiting for a cipher key (key_ready = 1)
// EMIT  | presenting round key rk_round (rk_valid = 1)
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_rk;
  logic [3:0]   r_round;
  logic         w_load;
  logic         w_step;

  word_t w_w0, w_w1, w_w2, w_w3;
  word_t w_rot, w_sub, w_t;
  word_t w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (
      .i_in  (w_rot[8*g +: 8]),
      .o_out (w_sub[8*g +: 8])
    );
  end

  assign w_t  = w_sub ^ {rcon_lookup(r_round + 4'd1), 24'h000000};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (key_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // Key input is ignored here, so the round-10 handshake never overlaps a load.
        if (rk_ready) begin
          if (r_round == LAST_ROUND) w_state_nxt = ST_IDLE;
          else                       w_step      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rk    <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_rk    <= key;
        r_round <= 4'd0;
      end else if (w_step) begin
        r_rk    <= {w_n0, w_n1, w_n2, w_n3};
        r_round <= r_round + 4'd1;
      end
    end
  end

  assign key_ready = (r_state == ST_IDLE);
  assign rk_valid  = (r_state == ST_EMIT);
  assign rk        = r_rk;
  assign rk_round  = r_round;
  assign rk_last   = (r_round == LAST_ROUND);

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors through a
// round-key scoreboard, with backpressure, ignored keys, reset and back-to-back loads.
module tb_aes_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] rk;
    int           round;
    bit           chk_rk;
  } sb_t;

  sb_t sb_q[$];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;

  logic [127:0] fips_rk [0:10];

  aes_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk        (rk),
    .rk_round  (rk_round),
    .rk_last   (rk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_fips();
    for (int r = 0; r <= 10; r++) sb_q.push_back('{rk: fips_rk[r], round: r, chk_rk: 1'b1});
  endtask

  task automatic push_k2();
    for (int r = 0; r <= 10; r++)
      sb_q.push_back('{rk: (r == 0) ? K2 : K2_R10, round: r, chk_rk: (r == 0 || r == 10)});
  endtask

  // Called one cycle after a key handshake, inputs driven #1 after posedge.
  // Compares every presented round key against the queue head; pops on handshake.
  task automatic sb_drain(input int budget, input int stall_round, input int stall_len,
                          input int pulse_round, input bit hold_kv);
    sb_t exp;
    int  stall_left = stall_len;
    int  cyc = 0;
    while (sb_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      exp = sb_q[0];
      checks++;
      if (rk_valid !== 1'b1 || key_ready !== 1'b0) begin
        errors++;
        $display("FAIL emit_flags round %0d: rk_valid=%b key_ready=%b, required 1/0",
                 exp.round, rk_valid, key_ready);
      end
      if (rk_valid) begin
        checks++;
        if (rk_round !== 4'(exp.round) || rk_last !== (exp.round == 10)) begin
          errors++;
          $display("FAIL rk_round got %0d last=%b, required %0d last=%b",
                   rk_round, rk_last, exp.round, (exp.round == 10));
        end
        if (exp.chk_rk) begin
          checks++;
          if (rk !== exp.rk) begin
            errors++;
            $display("FAIL rk round %0d got %h, required %h", exp.round, rk, exp.rk);
          end
        end
        if (rk_ready) void'(sb_q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
      if (rk_valid && int'(rk_round) == stall_round && stall_left > 0) begin
        rk_ready = 1'b0;
        stall_left--;
      end else begin
        rk_ready = 1'b1;
      end
      if (hold_kv) begin
        key_valid = 1'b1;
        key       = K2;
      end else if (rk_valid && int'(rk_round) == pulse_round) begin
        key_valid = 1'b1;
        key       = K3;
      end else begin
        key_valid = 1'b0;
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout remaining %0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key       = k;
    rk_ready  = 1'b1;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready got %b, required 1", key_ready);
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s key_ready=%b rk_valid=%b, required 1/0", tag, key_ready, rk_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key = '0; rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || rk !== '0 || rk_round !== 4'd0 || rk_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state kr=%b rv=%b rk=%h rnd=%0d last=%b, required 1 0 0 0 0",
               key_ready, rk_valid, rk, rk_round, rk_last);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    load_key(K1);
    push_fips();
    sb_drain(40, -1, 0, -1, 1'b0);
    check_idle("fips_idle_after_r10");
  endtask

  task automatic test_k2();
    load_key(K2);
    push_k2();
    sb_drain(40, -1, 0, -1, 1'b0);
    check_idle("k2_idle_after_r10");
  endtask

  task automatic test_backpressure();
    load_key(K1);
    push_fips();
    sb_drain(60, 3, 5, -1, 1'b0);
    check_idle("bp_idle_after_r10");
  endtask

  task automatic test_ignore_key();
    load_key(K1);
    push_fips();
    sb_drain(40, -1, 0, 2, 1'b0);
    check_idle("ignore_idle_after_r10");
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    load_key(K1);
    while (!(rk_valid && rk_round == 4'd5) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 30) begin
      errors++;
      $display("FAIL reach_round5 timeout rk_round=%0d, required 5", rk_round);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rk_valid !== 1'b0 || rk !== '0 || rk_round !== 4'd0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid rv=%b rk=%h rnd=%0d kr=%b, required 0 0 0 1",
               rk_valid, rk, rk_round, key_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset kr=%b rv=%b, required 1 0", key_ready, rk_valid);
    end
    load_key(K1);
    push_fips();
    sb_drain(40, -1, 0, -1, 1'b0);
    check_idle("restart_idle_after_r10");
  endtask

  task automatic test_back_to_back();
    load_key(K1);
    push_fips();
    sb_drain(40, -1, 0, -1, 1'b1);
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept key_ready=%b, required 1", key_ready);
    end
    push_k2();
    @(posedge clk); #1;
    key_valid = 1'b0;
    sb_drain(40, -1, 0, -1, 1'b0);
    check_idle("b2b_idle_after_r10");
  endtask

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips();
    test_k2();
    test_backpressure();
    test_ignore_key();
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: key_valid  in  1  cipher key offered.
REQ-004 SHALL have port: key_ready  out  1  block idle, can accept a key.
REQ-005 SHALL have port: key  in  128  AES-128 cipher key; word w0 = key[127:96].
REQ-006 SHALL have port: rk_valid  out  1  round key presented.
REQ-007 SHALL have port: rk_ready  in  1  downstream round stage consumes the key.
REQ-008 SHALL have port: rk  out  128  round key, same word order as key.
REQ-009 SHALL have port: rk_round  out  4  round index 0..10 of rk.
REQ-010 SHALL have port: rk_last  out  1  high while rk_round == 10.

Function
REQ-011 SHALL implement FSM states IDLE and EMIT.
- IDLE: key_ready = 1, rk_valid = 0.
- EMIT: key_ready = 0, rk_valid = 1.
REQ-012 SHALL, in IDLE on key_valid & key_ready, load rk <= key and rk_round <= 0, then enter EMIT. Round 0 is valid the next cycle (latency 1).
REQ-013 SHALL hold rk, rk_round and rk_valid stable while rk_valid & !rk_ready (no drop, no change).
REQ-014 SHALL, in EMIT on rk_ready with rk_round < 10, load the next round key and increment rk_round; the next key is valid the following cycle with no bubble.
REQ-015 SHALL compute the next key from the current words w0..w3:
- t = SubWord(RotWord(w3)) ^ {rcon[rk_round+1], 24'h0}
- w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
REQ-016 SHALL use RotWord {a,b,c,d} -> {b,c,d,a}; SubWord applies the AES S-box per byte.
REQ-017 SHALL use rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-018 SHALL, in EMIT on rk_ready with rk_round == 10, return to IDLE; key_ready is high the next cycle.
REQ-019 SHALL NOT accept a new key in the same cycle as the round-10 handshake.
REQ-020 SHALL ignore key_valid while in EMIT; the key input is sampled only at the IDLE handshake.
REQ-021 SHALL keep rk and rk_round at their last values in IDLE; they are meaningful only while rk_valid.
REQ-022 SHALL drive rk_last = (rk_round == 10) combinationally from the registered rk_round.

Reset
REQ-023 SHALL, while rst_n = 0, force: state IDLE, rk = 0, rk_round = 0, rk_valid = 0, key_ready = 1 after release, rk_last = 0.
REQ-024 SHALL abort any in-progress schedule on reset assertion mid-EMIT; nothing resumes after release.

Structure
REQ-025 SHALL place the following in shared package aes_pkg:
- the rcon table
- the constant NUM_ROUNDS = 10
- a typedef for a 32-bit word
REQ-026 SHALL use four instances of one sub-module, aes_sbox (8-bit combinational byte substitution), for SubWord; this is the same S-box the encryption round uses.
REQ-027 SHALL register all outputs except rk_last, key_ready and rk_valid, which are decoded from registered state.

Verification
REQ-028 SHALL check FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready tied high:
- round 0 = key, one cycle after the handshake
- round 1 = a0fafe1788542cb123a339392a6c7605
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last = 1
- key_ready high the cycle after round 10
REQ-029 SHALL check key 000102030405060708090a0b0c0d0e0f: round 10 = 13111d7fe3944a17f307a78b4d2b30c5 after exactly 11 handshakes.
REQ-030 SHALL check backpressure: hold rk_ready low 5 cycles at round 3 -> rk and rk_round unchanged; round 4 follows the cycle after release, and the final keys match REQ-028.
REQ-031 SHALL check that key_valid pulsed with a different key during EMIT is ignored and the sequence still matches REQ-028.
REQ-032 SHALL check that rst_n asserted at round 5 drives rk_valid = 0 and rk = 0 immediately, with key_ready = 1 after release; a new key then restarts at round 0.
REQ-033 SHALL check the round-10 handshake with key_valid held high: key_ready = 0 that cycle, and the new key is accepted one cycle later.
